// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: next-PC select encoding
// and the trap vector width.
package pc_seq_pkg;

  localparam int TRAP_VEC_W = 8;

  typedef enum logic [2:0] {
    PC_INC   = 3'b000,
    PC_BUS   = 3'b001,
    PC_ADDER = 3'b010,
    PC_HOLD  = 3'b011,
    PC_CALL  = 3'b100,
    PC_RET   = 3'b101,
    PC_TRAP  = 3'b110
  } pcmux_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/datapath bundle for the PC sequencer. The master side is the
// control FSM plus address adder; the slave side is the sequencer itself.
interface pc_sequencer_if #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic                              LD_PC;
  logic [2:0]                        PCMUX;
  logic [WIDTH-1:0]                  DATA_BUS;
  logic [WIDTH-1:0]                  DATA_ADDER;
  logic [pc_seq_pkg::TRAP_VEC_W-1:0] TRAP_VEC;
  logic [WIDTH-1:0]                  PC_OUT;
  logic [CW-1:0]                     RAS_COUNT;
  logic                              RAS_EMPTY;
  logic                              RAS_FULL;
  logic                              RAS_OVF;
  logic                              RAS_UNF;

  modport master (
    output LD_PC, PCMUX, DATA_BUS, DATA_ADDER, TRAP_VEC,
    input  PC_OUT, RAS_COUNT, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
  );

  modport slave (
    input  LD_PC, PCMUX, DATA_BUS, DATA_ADDER, TRAP_VEC,
    output PC_OUT, RAS_COUNT, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry (count saturates, ovf pulses); a pop while empty changes nothing
// except an unf pulse. Entry contents are not reset.
module ras_stack #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic             full;
  logic             empty;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign ptr_inc  = (top_ptr == PW'(DEPTH - 1)) ? '0 : top_ptr + 1'b1;
  assign ptr_dec  = (top_ptr == '0) ? PW'(DEPTH - 1) : top_ptr - 1'b1;
  assign top_data = mem[top_ptr];

  // Entry storage: a push writes the slot just above the current top.
  always_ff @(posedge Clk) begin
    if (push) mem[ptr_inc] <= push_data;
  end

  // Top pointer, saturating count and the registered error pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      top_ptr <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      ovf <= push && full;
      unf <= pop && empty;
      if (push) begin
        top_ptr <= ptr_inc;
        if (!full) count <= count + 1'b1;
      end else if (pop && !empty) begin
        top_ptr <= ptr_dec;
        count   <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch address and picks the next one
// from increment, bus, adder, call, return or trap sources.
// Build option: define PC_SEQ_RAS_EN to include the return-address stack;
// without it CALL/TRAP push nothing and RET loads DATA_BUS (R7 path).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_BASE = '0
) (
  input logic           Clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] trap_target;

  assign pc_inc      = pc_q + 1'b1;
  assign trap_target = TRAP_BASE | WIDTH'(bus.TRAP_VEC);
  assign bus.PC_OUT  = pc_q;

`ifdef PC_SEQ_RAS_EN
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_count;

  // Stack traffic only happens on edges where the PC is being loaded.
  assign ras_push = bus.LD_PC && (bus.PCMUX == PC_CALL || bus.PCMUX == PC_TRAP);
  assign ras_pop  = bus.LD_PC && (bus.PCMUX == PC_RET);

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .count     (ras_count),
    .ovf       (bus.RAS_OVF),
    .unf       (bus.RAS_UNF)
  );

  assign bus.RAS_COUNT = ras_count;
  assign bus.RAS_EMPTY = (ras_count == '0);
  assign bus.RAS_FULL  = (ras_count == CW'(RAS_DEPTH));
`else
  assign bus.RAS_COUNT = CW'(0);
  assign bus.RAS_EMPTY = 1'b1;
  assign bus.RAS_FULL  = 1'b0;
  assign bus.RAS_OVF   = 1'b0;
  assign bus.RAS_UNF   = 1'b0;
`endif

  // Next-PC select; 3'b111 and HOLD keep the current value.
  always_comb begin
    pc_next = pc_q;
    case (bus.PCMUX)
      PC_INC:   pc_next = pc_inc;
      PC_BUS:   pc_next = bus.DATA_BUS;
      PC_ADDER: pc_next = bus.DATA_ADDER;
      PC_HOLD:  pc_next = pc_q;
      PC_CALL:  pc_next = bus.DATA_ADDER;
`ifdef PC_SEQ_RAS_EN
      PC_RET:   if (ras_count != '0) pc_next = ras_top;
`else
      PC_RET:   pc_next = bus.DATA_BUS;
`endif
      PC_TRAP:  pc_next = trap_target;
      default:  pc_next = pc_q;
    endcase
  end

  // PC register; LD_PC low freezes it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)          pc_q <= RESET_VEC;
    else if (bus.LD_PC) pc_q <= pc_next;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: reset checks, a vector table of
// non-stack operations, hand sequences for call/return/overflow/underflow/
// trap/async reset, then random traffic against a queue-based model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int          W       = 16;
  localparam int          D       = 4;
  localparam logic [15:0] RV      = 16'h3000;
  localparam logic [15:0] TB_BASE = 16'h0000;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  pc_sequencer_if #(.WIDTH(W), .RAS_DEPTH(D)) bus_if ();

  pc_sequencer #(
    .WIDTH     (W),
    .RAS_DEPTH (D),
    .RESET_VEC (RV),
    .TRAP_BASE (TB_BASE)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_ras [$];
  bit          m_ovf;
  bit          m_unf;

  typedef struct {
    logic        ld;
    logic [2:0]  mux;
    logic [15:0] b;
    logic [15:0] a;
    logic [7:0]  v;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = RV;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_push(input logic [15:0] x);
`ifdef PC_SEQ_RAS_EN
    if (m_ras.size() == D) begin
      void'(m_ras.pop_front());
      m_ovf = 1'b1;
    end
    m_ras.push_back(x);
`else
    if (x === 16'hxxxx) m_ovf = 1'b0;
`endif
  endtask

  task automatic model_step(input logic ld, input logic [2:0] mux,
                            input logic [15:0] b, input logic [15:0] a,
                            input logic [7:0] v);
    logic [15:0] nxt;
    nxt   = m_pc + 16'd1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (ld) begin
      case (mux)
        3'd0: m_pc = nxt;
        3'd1: m_pc = b;
        3'd2: m_pc = a;
        3'd4: begin model_push(nxt); m_pc = a; end
        3'd5: begin
`ifdef PC_SEQ_RAS_EN
          if (m_ras.size() == 0) m_unf = 1'b1;
          else                   m_pc  = m_ras.pop_back();
`else
          m_pc = b;
`endif
        end
        3'd6: begin model_push(nxt); m_pc = TB_BASE | {8'h00, v}; end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic ld, input logic [2:0] mux,
                      input logic [15:0] b, input logic [15:0] a,
                      input logic [7:0] v);
    bus_if.LD_PC      = ld;
    bus_if.PCMUX      = mux;
    bus_if.DATA_BUS   = b;
    bus_if.DATA_ADDER = a;
    bus_if.TRAP_VEC   = v;
    @(posedge Clk);
    model_step(ld, mux, b, a, v);
    #1;
  endtask

  task automatic check_model(input string name);
    chk({name, " pc"},    bus_if.PC_OUT,    m_pc);
    chk({name, " count"}, 32'(bus_if.RAS_COUNT), 32'(m_ras.size()));
    chk({name, " empty"}, bus_if.RAS_EMPTY, (m_ras.size() == 0));
    chk({name, " full"},  bus_if.RAS_FULL,  (m_ras.size() == D));
    chk({name, " ovf"},   bus_if.RAS_OVF,   m_ovf);
    chk({name, " unf"},   bus_if.RAS_UNF,   m_unf);
  endtask

  initial begin
    bus_if.LD_PC      = 1'b0;
    bus_if.PCMUX      = 3'd0;
    bus_if.DATA_BUS   = '0;
    bus_if.DATA_ADDER = '0;
    bus_if.TRAP_VEC   = '0;

    tbl[0] = '{1'b1, 3'd0, 16'h0000, 16'h0000, 8'h00, 16'h3004};
    tbl[1] = '{1'b1, 3'd1, 16'h1234, 16'h0000, 8'h00, 16'h1234};
    tbl[2] = '{1'b1, 3'd2, 16'h0000, 16'hFFFF, 8'h00, 16'hFFFF};
    tbl[3] = '{1'b1, 3'd0, 16'h0000, 16'h0000, 8'h00, 16'h0000};
    tbl[4] = '{1'b0, 3'd4, 16'h0000, 16'h4000, 8'h00, 16'h0000};
    tbl[5] = '{1'b1, 3'd3, 16'h7777, 16'h8888, 8'h00, 16'h0000};
    tbl[6] = '{1'b1, 3'd7, 16'hABCD, 16'h1111, 8'h00, 16'h0000};
    tbl[7] = '{1'b0, 3'd1, 16'h5555, 16'h0000, 8'h00, 16'h0000};
    tbl[8] = '{1'b1, 3'd0, 16'h0000, 16'h0000, 8'h00, 16'h0001};
    tbl[9] = '{1'b0, 3'd6, 16'h0000, 16'h0000, 8'h25, 16'h0001};

    // Reset state
    #12;
    chk("reset pc",    bus_if.PC_OUT,    16'h3000);
    chk("reset count", 32'(bus_if.RAS_COUNT), 0);
    chk("reset empty", bus_if.RAS_EMPTY, 1'b1);
    chk("reset full",  bus_if.RAS_FULL,  1'b0);
    chk("reset ovf",   bus_if.RAS_OVF,   1'b0);
    chk("reset unf",   bus_if.RAS_UNF,   1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();

    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 16'h0, 16'h0, 8'h0);
    chk("inc3 pc", bus_if.PC_OUT, 16'h3003);

    // Table of non-stack operations (stall, hold, wrap, 3'b111)
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].ld, tbl[i].mux, tbl[i].b, tbl[i].a, tbl[i].v);
      chk($sformatf("tbl%0d pc", i),    bus_if.PC_OUT, tbl[i].exp_pc);
      chk($sformatf("tbl%0d count", i), 32'(bus_if.RAS_COUNT), 0);
      chk($sformatf("tbl%0d pulse", i), {bus_if.RAS_OVF, bus_if.RAS_UNF}, 2'b00);
    end

    // Call then immediate return
    step(1'b1, 3'd1, 16'h3010, 16'h0, 8'h0);
    step(1'b1, 3'd4, 16'h5555, 16'h4000, 8'h0);
    chk("call pc", bus_if.PC_OUT, 16'h4000);
`ifdef PC_SEQ_RAS_EN
    chk("call count", 32'(bus_if.RAS_COUNT), 1);
`else
    chk("call count", 32'(bus_if.RAS_COUNT), 0);
`endif
    step(1'b1, 3'd5, 16'h5555, 16'h0, 8'h0);
`ifdef PC_SEQ_RAS_EN
    chk("ret pc", bus_if.PC_OUT, 16'h3011);
`else
    chk("ret pc", bus_if.PC_OUT, 16'h5555);
`endif
    chk("ret empty", bus_if.RAS_EMPTY, 1'b1);

    // Overflow: five calls into a four-deep stack
`ifdef PC_SEQ_RAS_EN
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'd1, 16'h1000 + 16'(i * 256), 16'h0, 8'h0);
      step(1'b1, 3'd4, 16'h0, 16'h8000, 8'h0);
      chk($sformatf("ovf call%0d", i),  bus_if.RAS_OVF,  (i == 4));
      chk($sformatf("full call%0d", i), bus_if.RAS_FULL, (i >= 3));
    end
    step(1'b1, 3'd3, 16'h0, 16'h0, 8'h0);
    chk("ovf cleared", bus_if.RAS_OVF, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      step(1'b1, 3'd5, 16'h0, 16'h0, 8'h0);
      chk($sformatf("ovf ret%0d", i), bus_if.PC_OUT, 16'h1001 + 16'(i * 256));
    end
    chk("ovf drained", bus_if.RAS_EMPTY, 1'b1);
`else
    step(1'b1, 3'd4, 16'h0, 16'h8000, 8'h0);
    chk("norас call count", 32'(bus_if.RAS_COUNT), 0);
    chk("noras call ovf", bus_if.RAS_OVF, 1'b0);
`endif

    // Underflow
    step(1'b1, 3'd1, 16'h3020, 16'h0, 8'h0);
    step(1'b1, 3'd5, 16'h5555, 16'h0, 8'h0);
`ifdef PC_SEQ_RAS_EN
    chk("unf pc",  bus_if.PC_OUT,  16'h3020);
    chk("unf set", bus_if.RAS_UNF, 1'b1);
    step(1'b1, 3'd3, 16'h0, 16'h0, 8'h0);
    chk("unf clr", bus_if.RAS_UNF, 1'b0);
`else
    chk("unf pc",  bus_if.PC_OUT,  16'h5555);
    chk("unf set", bus_if.RAS_UNF, 1'b0);
`endif

    // Trap
    step(1'b1, 3'd6, 16'h0, 16'h0, 8'h25);
    chk("trap pc", bus_if.PC_OUT, 16'h0025);
`ifdef PC_SEQ_RAS_EN
    chk("trap count", 32'(bus_if.RAS_COUNT), 1);
`else
    chk("trap count", 32'(bus_if.RAS_COUNT), 0);
`endif

    // Asynchronous reset between edges
    #3;
    Reset = 1'b1;
    #1;
    chk("async pc",    bus_if.PC_OUT,    16'h3000);
    chk("async count", 32'(bus_if.RAS_COUNT), 0);
    chk("async empty", bus_if.RAS_EMPTY, 1'b1);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic        ld;
      logic [2:0]  mux;
      ld  = ($urandom_range(0, 4) != 0);
      mux = 3'($urandom_range(0, 7));
      step(ld, mux, 16'($urandom), 16'($urandom), 8'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer, successor to the LC-3 datapath PC register. Holds the fetch address and selects its next value from increment, bus, address adder, call, return or trap sources. A configurable return-address stack (RAS) supports subroutine call/return. It sits in the datapath between the control FSM (`LD_PC`, `PCMUX`) and the memory address path (`PC_OUT` → MAR mux).

## Interface
- `WIDTH`, 16 — PC and data width in bits.
- `RAS_DEPTH`, 4 — return-address stack entries; must be ≥ 2.
- `RESET_VEC`, 16'h0000 — PC value after reset (WIDTH bits).
- `TRAP_BASE`, 16'h0000 — base OR'ed with the zero-extended trap vector.

- `Clk` in 1 — system clock, all state updates on rising edge.
- `Reset` in 1 — asynchronous, active-high reset.
- `LD_PC` in 1 — enables a PC update this cycle; 0 freezes PC and RAS.
- `PCMUX` in 3 — next-PC select, encoding in Operation.
- `DATA_BUS` in WIDTH — bus value (JMP/RET-from-register path).
- `DATA_ADDER` in WIDTH — address adder result (BR/JSR target).
- `TRAP_VEC` in 8 — trap vector number.
- `PC_OUT` out WIDTH — current PC, registered.
- `RAS_COUNT` out $clog2(RAS_DEPTH+1) — valid RAS entries.
- `RAS_EMPTY` out 1 — `RAS_COUNT == 0`.
- `RAS_FULL` out 1 — `RAS_COUNT == RAS_DEPTH`.
- `RAS_OVF` out 1 — one-cycle pulse: CALL executed while full.
- `RAS_UNF` out 1 — one-cycle pulse: RET attempted while empty.

## Operation
PCMUX encoding applies only when `LD_PC=1`:
- 000 INC — PC ← PC+1 (mod 2^WIDTH).
- 001 BUS — PC ← `DATA_BUS`.
- 010 ADDER — PC ← `DATA_ADDER`.
- 011 HOLD — PC unchanged. The 3'b111 encoding behaves as HOLD.
- 100 CALL — PC ← `DATA_ADDER`; push PC+1.
- 101 RET — if the RAS is non-empty, PC ← top entry and pop. If empty, PC unchanged and `RAS_UNF` pulses.
- 110 TRAP — PC ← `TRAP_BASE | {zero-extend TRAP_VEC}`; push PC+1.

RAS behaviour:
- Circular buffer with a top pointer and a saturating count.
- A push while full overwrites the oldest entry. Count stays at `RAS_DEPTH` and `RAS_OVF` pulses.
- The pointer wraps modulo `RAS_DEPTH`.
- `LD_PC=0`: no PC change, no push or pop, no pulses, regardless of `PCMUX`.
- Reset state: `PC_OUT=RESET_VEC`, `RAS_COUNT=0`, `RAS_EMPTY=1`, `RAS_FULL=0`, `RAS_OVF=0`, `RAS_UNF=0`. RAS entry contents are don't-care.

## Timing
- PC and RAS update on the rising edge of `Clk` when `LD_PC=1`. The new `PC_OUT` is visible in the next cycle (single-cycle latency).
- `RAS_OVF` and `RAS_UNF` are registered and high for exactly the cycle following the offending edge.
- `RAS_COUNT`, `RAS_EMPTY` and `RAS_FULL` are registered and consistent with the RAS contents after each edge.
- A CALL immediately followed by a RET returns to the CALL address + 1 with no bubble.
- `Reset` asserted mid-sequence forces the reset state immediately (asynchronously). Any pending push or pop is discarded.
- Data inputs are sampled only at edges where `LD_PC=1`.

## Configuration
- `PC_SEQ_RAS_EN` defined: the RAS is present and behaves as described above.
- `PC_SEQ_RAS_EN` undefined: no RAS storage is built.
  - CALL and TRAP load their targets with no push.
  - RET behaves as BUS (PC ← `DATA_BUS`, the LC-3 R7 path).
  - `RAS_COUNT=0`, `RAS_EMPTY=1`; `RAS_FULL`, `RAS_OVF` and `RAS_UNF` are tied 0.

## Structure
- Package `pc_seq_pkg`:
  - `pcmux_e` enum (3-bit: PC_INC, PC_BUS, PC_ADDER, PC_HOLD, PC_CALL, PC_RET, PC_TRAP).
  - Trap vector width constant (8).
- Sub-module `ras_stack`:
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: `Clk`, `Reset`, `push`, `pop`, `push_data`, `top_data`, `count`, `ovf`, `unf`.
  - Instantiated only under `PC_SEQ_RAS_EN`.
- Next-PC mux and decode live in `pc_sequencer`.

## Test plan
- **Reset vector:** `RESET_VEC=16'h3000`, assert `Reset` → `PC_OUT=16'h3000`, `RAS_COUNT=0`, `RAS_EMPTY=1`. Then 3 INC cycles → `PC_OUT=16'h3003`.
- **Stall and wrap:** `PC_OUT=16'hFFFF`, INC → `16'h0000`. With `LD_PC=0` and `PCMUX=CALL` → PC and `RAS_COUNT` unchanged, no pulse.
- **Call/return:**
  - At `PC=16'h3010`, CALL with `DATA_ADDER=16'h4000` → `PC=16'h4000`, `RAS_COUNT=1`.
  - RET → `PC=16'h3011`, `RAS_EMPTY=1`.
- **Overflow:** `RAS_DEPTH=4`, 5 CALLs from PCs A..E → `RAS_OVF` pulses once after the 5th, `RAS_FULL=1`. 4 RETs then return E+1, D+1, C+1, B+1.
- **Underflow and trap:**
  - RET on an empty RAS at `PC=16'h3020` → PC stays `16'h3020`, `RAS_UNF` high for one cycle.
  - TRAP with `TRAP_VEC=8'h25` → `PC=16'h0025`, `RAS_COUNT=1`.
- **Build without `PC_SEQ_RAS_EN`:** RET with `DATA_BUS=16'h5555` → `PC=16'h5555`. CALL leaves `RAS_COUNT=0`.
